// File: rtl/signed_sat_accumulator_if.sv
// Stream bus for the saturating accumulator: sample input, result output and event count.
interface signed_sat_accumulator_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
);
   logic             clear;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic [WIDTH-1:0] out_acc;
   logic             out_sat;
   logic [CNT_W-1:0] sat_count;

   modport master (
      output clear, in_valid, in_data,
      input  out_valid, out_acc, out_sat, sat_count
   );

   modport slave (
      input  clear, in_valid, in_data,
      output out_valid, out_acc, out_sat, sat_count
   );
endinterface

// File: rtl/signed_sat_accumulator.sv
// Two-stage streaming two's-complement accumulator that clamps at the signed limits
// instead of wrapping, with a per-result saturation flag and a saturating event counter.
module signed_sat_accumulator #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   signed_sat_accumulator_if.slave  bus
);
   localparam int unsigned MSB = WIDTH - 1;
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             s1_valid_q,  s1_valid_d;
   logic [WIDTH-1:0] s1_data_q,   s1_data_d;
   logic [WIDTH-1:0] acc_q,       acc_d;
   logic             out_valid_q, out_valid_d;
   logic             out_sat_q,   out_sat_d;
   logic [CNT_W-1:0] sat_count_q, sat_count_d;

   logic [WIDTH-1:0] raw;
   logic             ovf;

   // Same-sign operands whose truncated sum flips sign have overflowed
   assign raw = acc_q + s1_data_q;
   assign ovf = (acc_q[MSB] == s1_data_q[MSB]) && (raw[MSB] != acc_q[MSB]);

   always_comb begin
      s1_valid_d  = bus.in_valid;
      s1_data_d   = bus.in_data;
      acc_d       = acc_q;
      out_valid_d = 1'b0;
      out_sat_d   = out_sat_q;
      sat_count_d = sat_count_q;

      if (bus.clear) begin
         s1_valid_d  = 1'b0;
         s1_data_d   = '0;
         acc_d       = '0;
         out_sat_d   = 1'b0;
         sat_count_d = '0;
      end else if (s1_valid_q) begin
         acc_d       = ovf ? (acc_q[MSB] ? MIN_NEG : MAX_POS) : raw;
         out_sat_d   = ovf;
         out_valid_d = 1'b1;
         if (ovf && (sat_count_q != CNT_MAX)) begin
            sat_count_d = sat_count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_sat_q   <= 1'b0;
         sat_count_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_sat_q   <= out_sat_d;
         sat_count_q <= sat_count_d;
      end
   end

   // The accumulator register doubles as the registered result output
   assign bus.out_valid = out_valid_q;
   assign bus.out_acc   = acc_q;
   assign bus.out_sat   = out_sat_q;
   assign bus.sat_count = sat_count_q;
endmodule

// File: doc/signed_sat_accumulator.md
Name: signed_sat_accumulator

Overview:
Streaming two's-complement accumulator placed directly downstream of the signed add-with-overflow stage. Each valid input sample is added to a running sum using the same overflow rule: operands of equal sign whose result sign differs. On overflow the sum clamps to the representable limit instead of wrapping. The block has a two-stage pipeline, a per-result saturation flag and a saturating count of overflow events.

Parameters:
WIDTH, 4, data and accumulator width in bits, two's complement.
CNT_W, 8, width of the saturation event counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, independent of clk.
clear  input  1  synchronous clear of the accumulator, counter and pipeline; active high.
in_valid  input  1  in_data is valid this cycle; no backpressure, so every valid sample is accepted.
in_data  input  WIDTH  signed addend.
out_valid  output  1  one-cycle pulse per accepted sample; out_acc and out_sat are meaningful only while it is high.
out_acc  output  WIDTH  accumulator value after this sample's update.
out_sat  output  1  this sample's update overflowed and was clamped.
sat_count  output  CNT_W  number of clamped updates since reset or clear; saturates at all-ones.

Behaviour:
- Reset (rst=0): s1_valid=0, s1_data=0, acc=0, out_valid=0, out_acc=0, out_sat=0, sat_count=0. All outputs are registered.
- Stage 1: on each edge, s1_valid <= in_valid and s1_data <= in_data. s1_data is don't-care while in_valid=0.
- Stage 2, on an edge with s1_valid=1:
  - raw = acc + s1_data, truncated to WIDTH.
  - ovf = (acc[MSB] == s1_data[MSB]) && (raw[MSB] != acc[MSB]).
  - Next acc = raw when ovf=0; when ovf=1, next acc = 2^(WIDTH-1)-1 if acc is non-negative, else -2^(WIDTH-1).
  - out_acc <= next acc, out_sat <= ovf, out_valid <= 1.
  - If ovf=1 and sat_count is not all-ones, sat_count increments by 1.
- Stage 2, on an edge with s1_valid=0: out_valid <= 0; out_acc, out_sat, acc and sat_count hold.
- Latency: a sample presented in cycle t appears on the outputs in cycle t+2. Full throughput, one sample per cycle; back-to-back samples chain through acc with no bubbles.
- clear=1 at an edge has priority over everything except rst:
  - acc=0, sat_count=0, s1_valid=0, out_valid=0, out_acc=0, out_sat=0.
  - The sample in stage 1 and any in_valid sample in the same cycle are discarded.
  - Samples presented from the cycle after clear onward accumulate normally from 0.
- Boundaries:
  - Adding 0 never overflows.
  - Opposite-sign operands never overflow.
  - With acc at a limit, further same-direction addends keep the value clamped and count again each time.
  - sat_count stays at all-ones once reached; it never wraps.
- rst asserted mid-stream: outputs reach reset values immediately. In-flight samples are lost. The first edge after rst deasserts captures inputs normally.

Test Plan:
- Reset, then samples 3, 2, 4 on consecutive cycles -> out_valid high 2 cycles after each; out_acc = 3, 5, 7; out_sat = 0, 0, 1; sat_count ends at 1.
- From acc=7, samples -8, -8, -1 -> out_acc = -1, -8, -8; out_sat = 0, 1, 1; sat_count rises by 2.
- Samples 1, idle, idle, 2, idle, -3 -> out_valid pulses only for the three samples; out_acc = 1, 3, 0; outputs hold across gaps.
- Accumulate to 5, then assert clear together with in_valid=1, in_data=6 while another sample is in stage 1 -> next cycle out_valid=0, out_acc=0, sat_count=0; the next sample of 2 yields out_acc=2.
- CNT_W=2: drive four clamping samples of +7 after acc reaches 7 -> sat_count goes 1, 2, 3, 3 (no wrap) and out_acc stays 7.
- Drop rst for a half-cycle between clock edges mid-stream -> all outputs zero immediately; after release, sample 4 gives out_acc=4 two cycles later.
